multimode_register: RTL and testbench

//  Parametrised N-bit operand register for the calculator datapath; successor to the plain clear/enable register.

---
 rtl/multimode_register_pkg.sv | 24 ++
 rtl/mmreg_shift_step.sv | 38 +++
 rtl/multimode_register.sv | 151 +++++++++++++++
 tb/tb_multimode_register.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multimode_register_pkg.sv
// Shared types and helpers for the multimode operand register.
package multimode_register_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_INC  = 3'b010,
    MODE_DEC  = 3'b011,
    MODE_SHL  = 3'b100,
    MODE_SHR  = 3'b101,
    MODE_ROL  = 3'b110,
    MODE_ROR  = 3'b111
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int unsigned clamp_shamt(input int unsigned shamt, input int unsigned n);
    return (shamt > n) ? n : shamt;
  endfunction

endpackage

// File: rtl/mmreg_shift_step.sv
// One-bit shift/rotate step; non-shift modes pass the value through unchanged.
module mmreg_shift_step
  import multimode_register_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  input  mode_e        mode,
  input  logic         sin,
  output logic [N-1:0] next_q,
  output logic         out_bit
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (mode)
      MODE_SHL: begin
        next_q  = {q[N-2:0], sin};
        out_bit = q[N-1];
      end
      MODE_SHR: begin
        next_q  = {sin, q[N-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        next_q  = {q[N-2:0], q[N-1]};
        out_bit = q[N-1];
      end
      MODE_ROR: begin
        next_q  = {q[0], q[N-1:1]};
        out_bit = q[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multimode_register.sv
// N-bit operand register: load, inc/dec, multi-cycle shift/rotate with BUSY/DONE handshake.
// Define MMREG_SYNC_CLR_EN to add the synchronous clear input SCLR.
module multimode_register
  import multimode_register_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N) + 1
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          CE,
  input  logic          START,
  input  logic [2:0]    MODE,
  input  logic [N-1:0]  D,
  input  logic [SW-1:0] SHAMT,
  input  logic          SIN,
  output logic [N-1:0]  Q,
  output logic          COUT,
  output logic          ZERO,
  output logic          BUSY,
  output logic          DONE
`ifdef MMREG_SYNC_CLR_EN
  ,
  input  logic          SCLR
`endif
);

  localparam logic [SW-1:0] ONE = SW'(1);

  state_e        state, state_n;
  logic [N-1:0]  q, q_n;
  logic          cout, cout_n;
  logic          done, done_n;
  logic [SW-1:0] count, count_n;
  logic [SW-1:0] k;
  mode_e         mode_r, mode_n, step_mode;
  logic          sin_r, sin_n, step_sin;
  logic [N-1:0]  step_q;
  logic          step_out;
  logic          sclr;

`ifdef MMREG_SYNC_CLR_EN
  assign sclr = SCLR;
`else
  assign sclr = 1'b0;
`endif

  assign k = SW'(clamp_shamt(32'(SHAMT), N));

  // The first step runs on the START edge from the live inputs; later steps use the latched copies.
  assign step_mode = (state == IDLE) ? mode_e'(MODE) : mode_r;
  assign step_sin  = (state == IDLE) ? SIN : sin_r;

  mmreg_shift_step #(.N(N)) u_step (
    .q       (q),
    .mode    (step_mode),
    .sin     (step_sin),
    .next_q  (step_q),
    .out_bit (step_out)
  );

  always_comb begin
    state_n = state;
    q_n     = q;
    cout_n  = cout;
    done_n  = 1'b0;
    count_n = count;
    mode_n  = mode_r;
    sin_n   = sin_r;
    case (state)
      IDLE: begin
        if (START) begin
          case (mode_e'(MODE))
            MODE_HOLD: done_n = 1'b1;
            MODE_LOAD: begin
              q_n    = D;
              cout_n = 1'b0;
              done_n = 1'b1;
            end
            MODE_INC: begin
              {cout_n, q_n} = {1'b0, q} + (N+1)'(1);
              done_n        = 1'b1;
            end
            MODE_DEC: begin
              {cout_n, q_n} = {1'b0, q} - (N+1)'(1);
              done_n        = 1'b1;
            end
            default: begin
              mode_n = mode_e'(MODE);
              sin_n  = SIN;
              if (k == '0) begin
                done_n = 1'b1;
              end else begin
                q_n     = step_q;
                cout_n  = step_out;
                count_n = k - ONE;
                if (k == ONE) done_n  = 1'b1;
                else          state_n = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        q_n     = step_q;
        cout_n  = step_out;
        count_n = count - ONE;
        if (count == ONE) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state  <= IDLE;
      q      <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      mode_r <= MODE_HOLD;
      sin_r  <= 1'b0;
    end else if (sclr) begin
      state  <= IDLE;
      q      <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      mode_r <= MODE_HOLD;
      sin_r  <= 1'b0;
    end else if (CE) begin
      state  <= state_n;
      q      <= q_n;
      cout   <= cout_n;
      done   <= done_n;
      count  <= count_n;
      mode_r <= mode_n;
      sin_r  <= sin_n;
    end
  end

  assign Q    = q;
  assign COUT = cout;
  assign ZERO = (q == '0);
  assign BUSY = (state == SHIFT);
  assign DONE = done;

endmodule

// File: tb/tb_multimode_register.sv
// Bench for multimode_register: N=4 and N=8 instances on shared stimulus, checked against a behavioural model.
// Build with MMREG_SYNC_CLR_EN defined to also exercise SCLR.
module tb_multimode_register;
  import multimode_register_pkg::*;

  logic       clk   = 1'b0;
  logic       clr_n = 1'b0;
  logic       ce    = 1'b1;
  logic       start = 1'b0;
  logic       sin   = 1'b0;
  logic       sclr  = 1'b0;
  logic [2:0] mode  = 3'b000;
  logic [7:0] d     = 8'h00;
  logic [3:0] shamt = 4'h0;

  logic [3:0] q4;
  logic       cout4, zero4, busy4, done4;
  logic [7:0] q8;
  logic       cout8, zero8, busy8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multimode_register #(.N(4)) dut4 (
    .CLK(clk), .CLR(clr_n), .CE(ce), .START(start), .MODE(mode), .D(d[3:0]),
    .SHAMT(shamt[2:0]), .SIN(sin), .Q(q4), .COUT(cout4), .ZERO(zero4), .BUSY(busy4), .DONE(done4)
`ifdef MMREG_SYNC_CLR_EN
    , .SCLR(sclr)
`endif
  );

  multimode_register #(.N(8)) dut8 (
    .CLK(clk), .CLR(clr_n), .CE(ce), .START(start), .MODE(mode), .D(d),
    .SHAMT(shamt), .SIN(sin), .Q(q8), .COUT(cout8), .ZERO(zero8), .BUSY(busy8), .DONE(done8)
`ifdef MMREG_SYNC_CLR_EN
    , .SCLR(sclr)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 is the 4-bit instance, index 1 the 8-bit one.
  // mrem counts shifts still owed after the START edge; BUSY is simply mrem > 0.
  int mq[2], mc[2], md[2], mrem[2], mmode[2], msin[2];

  function automatic int wid(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  task automatic mreset(input int i);
    mq[i] = 0; mc[i] = 0; md[i] = 0; mrem[i] = 0; mmode[i] = 0; msin[i] = 0;
  endtask

  task automatic shift_once(input int i);
    int w, mask, top, low;
    w = wid(i);
    mask = (1 << w) - 1;
    top = (mq[i] >> (w - 1)) & 1;
    low = mq[i] & 1;
    case (mmode[i])
      4: begin mc[i] = top; mq[i] = ((mq[i] << 1) | msin[i]) & mask; end
      5: begin mc[i] = low; mq[i] = (mq[i] >> 1) | (msin[i] << (w - 1)); end
      6: begin mc[i] = top; mq[i] = ((mq[i] << 1) | top) & mask; end
      default: begin mc[i] = low; mq[i] = (mq[i] >> 1) | (low << (w - 1)); end
    endcase
  endtask

  task automatic model_edge(input int i);
    int w, mask, sh, k, s;
    w = wid(i);
    mask = (1 << w) - 1;
    md[i] = 0;
    if (mrem[i] > 0) begin
      shift_once(i);
      mrem[i]--;
      if (mrem[i] == 0) md[i] = 1;
    end else if (start) begin
      case (int'(mode))
        0: md[i] = 1;
        1: begin mq[i] = int'(d) & mask; mc[i] = 0; md[i] = 1; end
        2: begin s = mq[i] + 1; mc[i] = s >> w; mq[i] = s & mask; md[i] = 1; end
        3: begin mc[i] = (mq[i] == 0) ? 1 : 0; mq[i] = (mq[i] + mask) & mask; md[i] = 1; end
        default: begin
          mmode[i] = int'(mode);
          msin[i]  = int'(sin);
          sh = (i == 0) ? (int'(shamt) & 7) : int'(shamt);
          k  = (sh > w) ? w : sh;
          if (k == 0) md[i] = 1;
          else begin
            shift_once(i);
            mrem[i] = k - 1;
            if (mrem[i] == 0) md[i] = 1;
          end
        end
      endcase
    end
  endtask

  always @(posedge clk or negedge clr_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!clr_n || sclr) mreset(i);
      else if (ce) model_edge(i);
    end
  end

  always @(negedge clk) begin
    chk("q4", int'(q4), mq[0]);
    chk("cout4", int'(cout4), mc[0]);
    chk("zero4", int'(zero4), (mq[0] == 0) ? 1 : 0);
    chk("busy4", int'(busy4), (mrem[0] > 0) ? 1 : 0);
    chk("done4", int'(done4), md[0]);
    chk("q8", int'(q8), mq[1]);
    chk("cout8", int'(cout8), mc[1]);
    chk("zero8", int'(zero8), (mq[1] == 0) ? 1 : 0);
    chk("busy8", int'(busy8), (mrem[1] > 0) ? 1 : 0);
    chk("done8", int'(done8), md[1]);
  end

  task automatic op(input logic st, input logic [2:0] m, input logic [7:0] dv,
                    input logic [3:0] sh, input logic sn, input logic cev);
    start = st; mode = m; d = dv; shamt = sh; sin = sn; ce = cev;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    op(1'b0, 3'b000, 8'h00, 4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    #2;
    chk("rst_q4", int'(q4), 0);
    chk("rst_q8", int'(q8), 0);
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_done4", int'(done4), 0);
    chk("rst_cout8", int'(cout8), 0);
    clr_n = 1'b1;

    op(1'b1, MODE_LOAD, 8'hFA, 4'h0, 1'b0, 1'b1);
    chk("load_q4", int'(q4), 'hA);
    chk("load_done4", int'(done4), 1);
    chk("load_cout4", int'(cout4), 0);
    chk("load_q8", int'(q8), 'hFA);
    op(1'b1, MODE_LOAD, 8'hFF, 4'h0, 1'b0, 1'b1);
    op(1'b1, MODE_INC, 8'h00, 4'h0, 1'b0, 1'b1);
    chk("inc_q4", int'(q4), 0);
    chk("inc_cout4", int'(cout4), 1);
    chk("inc_zero4", int'(zero4), 1);
    chk("inc_q8", int'(q8), 0);
    op(1'b1, MODE_DEC, 8'h00, 4'h0, 1'b0, 1'b1);
    chk("dec_q4", int'(q4), 'hF);
    chk("dec_cout4", int'(cout4), 1);
    chk("dec_q8", int'(q8), 'hFF);

    op(1'b1, MODE_LOAD, 8'h81, 4'h0, 1'b0, 1'b1);
    op(1'b1, MODE_ROL, 8'h00, 4'h3, 1'b0, 1'b1);
    chk("rol_busy8_a", int'(busy8), 1);
    chk("rol_q8_a", int'(q8), 'h03);
    idle();
    chk("rol_busy8_b", int'(busy8), 1);
    chk("rol_done8_b", int'(done8), 0);
    idle();
    chk("rol_busy8_c", int'(busy8), 0);
    chk("rol_done8_c", int'(done8), 1);
    chk("rol_q8", int'(q8), 'h0C);
    chk("rol_cout8", int'(cout8), 0);

    op(1'b1, MODE_LOAD, 8'h0B, 4'h0, 1'b0, 1'b1);
    op(1'b1, MODE_SHR, 8'h00, 4'h7, 1'b1, 1'b1);
    repeat (3) idle();
    chk("shr_q4", int'(q4), 'hF);
    chk("shr_cout4", int'(cout4), 1);
    chk("shr_done4", int'(done4), 1);
    chk("shr_busy8", int'(busy8), 1);
    repeat (3) idle();
    chk("shr_done8", int'(done8), 1);
    chk("shr_q8", int'(q8), 'hFE);
    chk("shr_cout8", int'(cout8), 0);
    op(1'b1, MODE_SHR, 8'h00, 4'h0, 1'b1, 1'b1);
    chk("k0_done4", int'(done4), 1);
    chk("k0_q4", int'(q4), 'hF);
    chk("k0_busy4", int'(busy4), 0);
    chk("k0_q8", int'(q8), 'hFE);

    op(1'b1, MODE_LOAD, 8'h01, 4'h0, 1'b0, 1'b1);
    op(1'b1, MODE_SHL, 8'h00, 4'h3, 1'b0, 1'b1);
    chk("ce_q4_a", int'(q4), 'h2);
    op(1'b0, MODE_HOLD, 8'h00, 4'h0, 1'b0, 1'b0);
    op(1'b0, MODE_HOLD, 8'h00, 4'h0, 1'b0, 1'b0);
    chk("ce_q4_frozen", int'(q4), 'h2);
    chk("ce_busy4_frozen", int'(busy4), 1);
    op(1'b1, MODE_LOAD, 8'hFF, 4'h0, 1'b0, 1'b1);
    chk("busy_start_ignored_q4", int'(q4), 'h4);
    idle();
    chk("ce_q4_end", int'(q4), 'h8);
    chk("ce_done4_end", int'(done4), 1);
    chk("ce_q8_end", int'(q8), 'h08);
    op(1'b0, MODE_HOLD, 8'h00, 4'h0, 1'b0, 1'b0);
    chk("done_held_ce0", int'(done4), 1);
    idle();
    chk("done_cleared", int'(done4), 0);

    op(1'b1, MODE_LOAD, 8'hFF, 4'h0, 1'b0, 1'b1);
    op(1'b1, MODE_SHL, 8'h00, 4'h6, 1'b0, 1'b1);
    repeat (2) idle();
    chk("clr_pre_busy8", int'(busy8), 1);
    clr_n = 1'b0;
    #1;
    chk("clr_q8", int'(q8), 0);
    chk("clr_busy8", int'(busy8), 0);
    chk("clr_done8", int'(done8), 0);
    clr_n = 1'b1;
    idle();
    chk("clr_idle_busy8", int'(busy8), 0);

`ifdef MMREG_SYNC_CLR_EN
    op(1'b1, MODE_LOAD, 8'hFF, 4'h0, 1'b0, 1'b1);
    op(1'b1, MODE_SHL, 8'h00, 4'h6, 1'b0, 1'b1);
    idle();
    sclr = 1'b1;
    op(1'b0, MODE_HOLD, 8'h00, 4'h0, 1'b0, 1'b0);
    sclr = 1'b0;
    chk("sclr_q8", int'(q8), 0);
    chk("sclr_busy8", int'(busy8), 0);
    chk("sclr_done8", int'(done8), 0);
    idle();
    chk("sclr_idle_busy8", int'(busy8), 0);
`endif

    repeat (3000) begin
`ifdef MMREG_SYNC_CLR_EN
      sclr = ($urandom_range(0, 49) == 0);
`endif
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 199) == 0) begin
        clr_n = 1'b0;
        #1;
        clr_n = 1'b1;
      end
    end
    sclr = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
